// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite engine: FSM encoding, colours, request bundle
// and the sprite shape.
package sprite_pkg;

    localparam logic [1:0] ST_DRAW   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_ERASE  = 2'd2;
    localparam logic [1:0] ST_UPDATE = 2'd3;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] WHITE = 3'b111;
    localparam logic [2:0] RED   = 3'b100;

    typedef struct packed {
        logic left;
        logic right;
        logic fire;
    } req_t;

    // Stem down the centre column, a crossbar on the middle row, a short base on the last row.
    function automatic logic sprite_white(input logic [3:0] c, input logic [3:0] r,
                                          input int w, input int h);
        int  ci;
        int  ri;
        logic on_stem;
        logic on_bar;
        logic on_base;
        ci      = int'(c);
        ri      = int'(r);
        on_stem = (ci == w / 2) && (ri >= 1);
        on_bar  = (ri == h / 2);
        on_base = (ri == h - 1) && (ci + 1 >= w / 2) && (ci <= w / 2 + 1);
        return on_stem || on_bar || on_base;
    endfunction

endpackage

// File: rtl/sprite_scan.sv
// Row-major column/row scan counter shared by the DRAW and ERASE passes.
module sprite_scan
    import sprite_pkg::*;
#(
    parameter int W = 5,
    parameter int H = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic       clr,
    output logic [3:0] c,
    output logic [3:0] r,
    output logic       last
);

    assign last = (c == 4'(W - 1)) && (r == 4'(H - 1));

    // NOTE: reset_n is sampled only on the clock edge, so it sits inside the clocked branch.
    always_ff @(posedge clk) begin
        if (!reset_n || clr) begin
            // NOTE: non-blocking assignments keep every register update based on pre-edge values.
            c <= '0;
            r <= '0;
        end else if (en) begin
            if (c == 4'(W - 1)) begin
                c <= '0;
                r <= last ? 4'd0 : r + 4'd1;
            end else begin
                c <= c + 4'd1;
            end
        end
    end

endmodule

// File: rtl/sprite_engine.sv
// Draw / wait / erase / update loop for a single sprite moving along a fixed row.
module sprite_engine
    import sprite_pkg::*;
#(
    parameter int SPRITE_W    = 5,
    parameter int SPRITE_H    = 5,
    parameter int WAIT_CYCLES = 26,
    parameter int X_INIT      = 80,
    parameter int X_MAX       = 160,
    parameter int Y_ROW       = 60
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       move_left,
    input  logic       move_right,
    input  logic       fire,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour,
    output logic       plot,
    output logic [7:0] pos_x,
    output logic       frame_done
);

    localparam logic [7:0] X_LIMIT = 8'(X_MAX - SPRITE_W);

    logic [1:0]  state;
    logic        armed;
    logic [15:0] wait_cnt;
    req_t        req;
    req_t        req_in;
    logic        frame_fire;
    logic [7:0]  next_x;
    logic [3:0]  c;
    logic [3:0]  r;
    logic        scan_last;
    logic        scanning;

    assign req_in   = '{left: move_left, right: move_right, fire: fire};
    assign scanning = (state == ST_DRAW) || (state == ST_ERASE);

    sprite_scan #(.W(SPRITE_W), .H(SPRITE_H)) u_scan (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (armed && scanning),
        .clr     (state == ST_UPDATE),
        .c       (c),
        .r       (r),
        .last    (scan_last)
    );

    always_comb begin
        next_x = pos_x;
        if (req.left && !req.right)
            next_x = (pos_x == 8'd0) ? 8'd0 : pos_x - 8'd1;
        else if (req.right && !req.left)
            next_x = (pos_x >= X_LIMIT) ? X_LIMIT : pos_x + 8'd1;
    end

    // armed holds off the first DRAW pixel for one cycle so the post-reset cycle is blank.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_DRAW;
            armed      <= 1'b0;
            wait_cnt   <= '0;
            req        <= '0;
            frame_fire <= 1'b0;
            pos_x      <= 8'(X_INIT);
        end else begin
            armed <= 1'b1;
            // A request landing in UPDATE starts the next frame's set instead of joining this one.
            req   <= (state == ST_UPDATE) ? req_in : (req | req_in);
            case (state)
                ST_DRAW: begin
                    if (armed && scan_last) begin
                        state    <= ST_WAIT;
                        wait_cnt <= '0;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 16'(WAIT_CYCLES - 1))
                        state <= ST_ERASE;
                    else
                        wait_cnt <= wait_cnt + 16'd1;
                end
                ST_ERASE: begin
                    if (scan_last)
                        state <= ST_UPDATE;
                end
                default: begin
                    pos_x      <= next_x;
                    frame_fire <= req.fire;
                    state      <= ST_DRAW;
                end
            endcase
        end
    end

    assign x_out      = pos_x + 8'(c);
    assign y_out      = 7'(Y_ROW) + 7'(r);
    assign plot       = reset_n && armed && scanning;
    assign frame_done = reset_n && (state == ST_UPDATE);

    // NOTE: colour gets a default first so no path through this block can infer a latch.
    always_comb begin
        colour = BLACK;
        if (plot && state == ST_DRAW) begin
            if (frame_fire && r == 4'd0 && c == 4'(SPRITE_W / 2))
                colour = RED;
            else if (sprite_white(c, r, SPRITE_W, SPRITE_H))
                colour = WHITE;
        end
    end

endmodule

// File: tb/tb_sprite_engine.sv
// Randomised bench for sprite_engine against a frame-time reference model.
module tb_sprite_engine;

    localparam int W   = 5;
    localparam int H   = 5;
    localparam int WC  = 26;
    localparam int XI  = 80;
    localparam int XM  = 160;
    localparam int YR  = 60;
    localparam int N   = W * H;
    localparam int UPD = 2 * N + WC;
    localparam int FRM = UPD + 1;

    logic       clk;
    logic       reset_n;
    logic       move_left;
    logic       move_right;
    logic       fire;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour;
    logic       plot;
    logic [7:0] pos_x;
    logic       frame_done;

    sprite_engine #(
        .SPRITE_W(W), .SPRITE_H(H), .WAIT_CYCLES(WC),
        .X_INIT(XI), .X_MAX(XM), .Y_ROW(YR)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .move_left  (move_left),
        .move_right (move_right),
        .fire       (fire),
        .x_out      (x_out),
        .y_out      (y_out),
        .colour     (colour),
        .plot       (plot),
        .pos_x      (pos_x),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Model: time index within the frame, position and pending requests.
    bit m_armed;
    int m_t;
    int m_pos;
    bit m_l, m_r, m_f, m_ff;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic logic rnd(input int n);
        return $urandom_range(0, n - 1) == 0;
    endfunction

    task automatic model_reset();
        m_armed = 0; m_t = 0; m_pos = XI;
        m_l = 0; m_r = 0; m_f = 0; m_ff = 0;
    endtask

    task automatic check_outputs(input logic rn);
        int c, r, k, d;
        logic       e_plot;
        logic [2:0] e_col;
        logic       e_done;
        e_plot = 0; e_col = 3'b000; e_done = 0; c = 0; r = 0;
        if (rn && m_armed) begin
            if (m_t < N) begin
                e_plot = 1;
                c = m_t % W;
                r = m_t / W;
                d = c - W / 2;
                if (d < 0) d = -d;
                if (m_ff && r == 0 && c == W / 2)
                    e_col = 3'b100;
                else if ((c == W / 2 && r >= 1) || r == H / 2 || (r == H - 1 && d <= 1))
                    e_col = 3'b111;
            end else if (m_t >= N + WC && m_t < UPD) begin
                e_plot = 1;
                k = m_t - N - WC;
                c = k % W;
                r = k / W;
            end else if (m_t == UPD) begin
                e_done = 1;
            end
        end
        check("plot", 32'(plot), 32'(e_plot));
        check("colour", 32'(colour), 32'(e_col));
        check("frame_done", 32'(frame_done), 32'(e_done));
        check("pos_x", 32'(pos_x), 32'(m_pos));
        if (e_plot) begin
            check("x_out", 32'(x_out), 32'(m_pos + c));
            check("y_out", 32'(y_out), 32'(YR + r));
        end
    endtask

    task automatic model_edge(input logic l, input logic rt, input logic f, input logic rn);
        if (!rn) begin
            model_reset();
        end else if (!m_armed) begin
            m_armed = 1;
            m_l |= l; m_r |= rt; m_f |= f;
        end else if (m_t == UPD) begin
            if (m_l && !m_r)
                m_pos = (m_pos > 0) ? m_pos - 1 : 0;
            else if (m_r && !m_l)
                m_pos = (m_pos < XM - W) ? m_pos + 1 : XM - W;
            m_ff = m_f;
            m_l = l; m_r = rt; m_f = f;
            m_t = 0;
        end else begin
            m_t++;
            m_l |= l; m_r |= rt; m_f |= f;
        end
    endtask

    task automatic step(input logic l, input logic rt, input logic f, input logic rn);
        @(negedge clk);
        move_left = l; move_right = rt; fire = f; reset_n = rn;
        #1;
        check_outputs(rn);
        model_edge(l, rt, f, rn);
    endtask

    // Idle until the model reaches frame time `target`; the next step lands on that cycle.
    task automatic wait_phase(input int target);
        int budget;
        budget = 3 * FRM;
        while (!(m_armed && m_t == target) && budget > 0) begin
            step(0, 0, 0, 1);
            budget--;
        end
        if (budget == 0) check("wait_phase_timeout", 32'(m_t), 32'(target));
    endtask

    initial begin
        reset_n = 1'b0; move_left = 1'b0; move_right = 1'b0; fire = 1'b0;
        model_reset();

        repeat (3) step(0, 0, 0, 0);
        repeat (2 * FRM + 1) step(0, 0, 0, 1);

        repeat (6 * FRM) step(rnd(16), rnd(16), rnd(8), 1);

        // Right pulse during WAIT, fire during ERASE, then a right pulse in the UPDATE cycle.
        wait_phase(N + 3);
        step(0, 1, 0, 1);
        wait_phase(N + WC + 4);
        step(0, 0, 1, 1);
        wait_phase(UPD);
        step(0, 1, 0, 1);
        repeat (2 * FRM) step(0, 0, 0, 1);

        repeat (90 * FRM) step(0, 1, rnd(32), 1);
        repeat (2 * FRM) step(1, 1, 0, 1);
        repeat (170 * FRM) step(1, 0, rnd(32), 1);
        repeat (2 * FRM) step(0, 0, 0, 1);

        // Reset on the 10th DRAW pixel.
        wait_phase(9);
        step(0, 0, 0, 0);
        repeat (FRM + 5) step(0, 0, 0, 1);

        repeat (8 * FRM) step(rnd(12), rnd(12), rnd(10), !rnd(500));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sprite_engine.md
SPRITE_ENGINE -- requirements
Module: sprite_engine

Interface
REQ-001 Parameter SPRITE_W, default 5, sprite width in pixels (3..15).
REQ-002 Parameter SPRITE_H, default 5, sprite height in pixels (3..15).
REQ-003 Parameter WAIT_CYCLES, default 26, number of cycles spent in WAIT per frame (>=1).
REQ-004 Parameter X_INIT, default 80, sprite left column after reset.
REQ-005 Parameter X_MAX, default 160, screen width; the sprite's rightmost column SHALL stay below X_MAX.
REQ-006 Parameter Y_ROW, default 60, sprite top row, fixed.
REQ-007 clk  input  1  clock; reset_n  input  1  reset: synchronous, active-low.
REQ-008 move_left  input  1  one-cycle request to move the sprite 1 px left.
REQ-009 move_right  input  1  one-cycle request to move the sprite 1 px right.
REQ-010 fire  input  1  one-cycle request to draw the fire variant on the next frame.
REQ-011 x_out  output  8  pixel column; y_out  output  7  pixel row.
REQ-012 colour  output  3  pixel colour as RGB (black 000, white 111, red 100).
REQ-013 plot  output  1  pixel write strobe.
REQ-014 pos_x  output  8  current sprite left column.
REQ-015 frame_done  output  1  one-cycle pulse in the UPDATE state.

Function
REQ-016 The FSM SHALL have the states DRAW, WAIT, ERASE and UPDATE, with the transitions DRAW->WAIT->ERASE->UPDATE->DRAW.
REQ-017 DRAW and ERASE SHALL each last exactly SPRITE_W*SPRITE_H cycles and emit one pixel per cycle in row-major order (c=0..W-1 inner loop, r=0..H-1 outer loop), with plot=1.
REQ-018 The pixel address SHALL be x_out=pos_x+c and y_out=Y_ROW+r, combinational from the scan counters, with zero latency.
REQ-019 WAIT SHALL last exactly WAIT_CYCLES cycles with plot=0; UPDATE SHALL last 1 cycle with plot=0.
REQ-020 In DRAW the colour SHALL be white when:
  - c==W/2 and r>=1, or
  - r==H/2, or
  - r==H-1 and |c-W/2|<=1.
  All other pixels SHALL be black.
REQ-021 In DRAW with the fire flag set, pixel (r=0, c=W/2) SHALL be red; all other pixels SHALL follow REQ-020.
REQ-022 In ERASE the colour SHALL be black for every pixel, with the scan identical to the preceding DRAW.
REQ-023 move_left, move_right and fire SHALL be sticky-latched in any state and cleared in UPDATE after they are applied.
REQ-024 pos_x SHALL change only in UPDATE, so the DRAW/ERASE pairs of one frame use the same position:
  - left only: pos_x-1, saturating at 0;
  - right only: pos_x+1, saturating at X_MAX-SPRITE_W;
  - both or neither: no change.
REQ-025 The fire flag SHALL be copied into a frame_fire register in UPDATE and hold for the whole next DRAW.
REQ-026 A request that arrives in the same cycle as UPDATE SHALL be latched for the following frame, not applied in that UPDATE.
REQ-027 All arithmetic SHALL be unsigned 8-bit; no wrap-around of pos_x SHALL occur.

Reset
REQ-028 reset_n=0 on a clk edge SHALL set:
  - state=DRAW, pos_x=X_INIT;
  - the scan and wait counters to 0;
  - all latched requests and frame_fire to 0.
REQ-029 During reset and in the cycle following it, the outputs SHALL be plot=0, colour=000 and frame_done=0.
REQ-030 A reset asserted mid-frame SHALL abandon the frame immediately; leftover pixels are not erased.

Structure
REQ-031 A shared package sprite_pkg SHALL hold the state encoding and the colour constants BLACK, WHITE and RED.
REQ-032 The row/column scan counter SHALL be a sub-module sprite_scan (parameters W and H; inputs en and clr; outputs c, r and last). It SHALL be instantiated once and shared by DRAW and ERASE.
REQ-033 The block SHALL use a single clock domain with no asynchronous logic; button edge-detection lies outside this block.

Verification
REQ-034 Reset then run one frame at defaults -> 25 plot cycles at x 80..84, y 60..64, with the white pattern per REQ-020 and no red; then 26 cycles of plot=0; then 25 black pixels; then a frame_done pulse.
REQ-035 move_right pulse during WAIT -> after UPDATE, pos_x=81 and the next DRAW spans x 81..85; the preceding ERASE still spans x 80..84.
REQ-036 With pos_x=0, pulse move_left -> pos_x stays 0; with pos_x=155 (X_MAX-W), pulse move_right -> pos_x stays 155.
REQ-037 fire pulse in ERASE -> the next DRAW outputs red at (pos_x+2, 60) and white elsewhere per pattern; the frame after that has no red.
REQ-038 move_left and move_right in the same cycle -> pos_x is unchanged; a request in the UPDATE cycle takes effect one frame later.
REQ-039 reset_n=0 on the 10th DRAW pixel -> the next cycle shows plot=0 and pos_x=80; the DRAW then restarts at pixel (0,0).
